// File: rtl/instruction_fetch_unit_if.sv
// Fetch-unit bundle: decode-side control, instruction memory read port and
// the {pc, instruction} stream handed to decode.
interface instruction_fetch_unit_if;
  logic        stall;
  logic        redirect_valid;
  logic [15:0] redirect_pc;
  logic        mem_req;
  logic [15:0] mem_addr;
  logic        mem_ack;
  logic [15:0] mem_rdata;
  logic [15:0] instruction;
  logic [15:0] if_pc;
  logic        if_valid;

  // Fetch unit side
  modport master (
    input  stall, redirect_valid, redirect_pc, mem_ack, mem_rdata,
    output mem_req, mem_addr, instruction, if_pc, if_valid
  );

  // Environment side (decode stage + instruction memory)
  modport slave (
    output stall, redirect_valid, redirect_pc, mem_ack, mem_rdata,
    input  mem_req, mem_addr, instruction, if_pc, if_valid
  );
endinterface

// File: rtl/instruction_fetch_unit.sv
// Instruction fetch unit: fetch PC, req/ack memory reader, small prefetch
// FIFO and a registered {pc, instruction, valid} stage toward decode.
module instruction_fetch_unit #(
  parameter logic [15:0] RESET_PC   = 16'h0000,
  parameter logic [15:0] NOP_WORD   = 16'h0800,
  parameter int unsigned FIFO_DEPTH = 2
) (
  input logic                      clk_i,
  input logic                      rst_i,
  instruction_fetch_unit_if.master bus
);
  localparam int unsigned PW = $clog2(FIFO_DEPTH);
  localparam int unsigned CW = PW + 1;

  typedef enum logic [1:0] {IDLE, REQ, DRAIN} state_e;

  state_e        state_q, state_d;
  logic [15:0]   fetch_pc_q, fetch_pc_d;
  logic [15:0]   pend_pc_q, pend_pc_d;
  logic          mem_req_q, mem_req_d;
  logic [15:0]   mem_addr_q, mem_addr_d;
  logic [15:0]   instr_q, instr_d;
  logic [15:0]   if_pc_q, if_pc_d;
  logic          if_valid_q, if_valid_d;

  logic [15:0]   fifo_pc_q   [FIFO_DEPTH];
  logic [15:0]   fifo_word_q [FIFO_DEPTH];
  logic [PW-1:0] rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic [CW-1:0] count_after_pop;
  logic          push, pop;

  assign bus.mem_req     = mem_req_q;
  assign bus.mem_addr    = mem_addr_q;
  assign bus.instruction = instr_q;
  assign bus.if_pc       = if_pc_q;
  assign bus.if_valid    = if_valid_q;

  // Pop decision is independent of push, so request gating can use it
  always_comb begin
    pop             = !bus.redirect_valid && !bus.stall && (count_q != '0);
    count_after_pop = count_q - CW'(pop);
  end

  // Fetch FSM: next state, request issue and fetch PC update
  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    pend_pc_d  = pend_pc_q;
    mem_req_d  = mem_req_q;
    mem_addr_d = mem_addr_q;
    push       = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.redirect_valid) begin
          fetch_pc_d = bus.redirect_pc;
        end else if (count_after_pop < CW'(FIFO_DEPTH)) begin
          mem_req_d  = 1'b1;
          mem_addr_d = fetch_pc_q;
          state_d    = REQ;
        end
      end
      REQ: begin
        if (bus.mem_ack) begin
          if (bus.redirect_valid) begin
            fetch_pc_d = bus.redirect_pc;
            mem_req_d  = 1'b0;
            state_d    = IDLE;
          end else begin
            push       = 1'b1;
            fetch_pc_d = mem_addr_q + 16'd1;
            // back-to-back only if the slot after this push+pop is still free
            if (count_after_pop < CW'(FIFO_DEPTH - 1)) begin
              mem_addr_d = mem_addr_q + 16'd1;
            end else begin
              mem_req_d = 1'b0;
              state_d   = IDLE;
            end
          end
        end else if (bus.redirect_valid) begin
          pend_pc_d = bus.redirect_pc;
          state_d   = DRAIN;
        end
      end
      DRAIN: begin
        if (bus.redirect_valid) pend_pc_d = bus.redirect_pc;
        if (bus.mem_ack) begin
          fetch_pc_d = bus.redirect_valid ? bus.redirect_pc : pend_pc_q;
          mem_req_d  = 1'b0;
          state_d    = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Output stage and FIFO bookkeeping: redirect flush > stall hold > pop > bubble
  always_comb begin
    instr_d    = instr_q;
    if_pc_d    = if_pc_q;
    if_valid_d = if_valid_q;
    rd_ptr_d   = rd_ptr_q;
    wr_ptr_d   = wr_ptr_q;
    count_d    = count_q;
    if (bus.redirect_valid) begin
      instr_d    = NOP_WORD;
      if_valid_d = 1'b0;
      rd_ptr_d   = '0;
      wr_ptr_d   = '0;
      count_d    = '0;
    end else begin
      if (!bus.stall) begin
        if (pop) begin
          instr_d    = fifo_word_q[rd_ptr_q];
          if_pc_d    = fifo_pc_q[rd_ptr_q];
          if_valid_d = 1'b1;
        end else begin
          instr_d    = NOP_WORD;
          if_valid_d = 1'b0;
        end
      end
      if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);
      if (push) wr_ptr_d = wr_ptr_q + PW'(1);
      count_d = count_q + CW'(push) - CW'(pop);
    end
  end

  // State registers with asynchronous reset
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= IDLE;
      fetch_pc_q <= RESET_PC;
      pend_pc_q  <= RESET_PC;
      mem_req_q  <= 1'b0;
      mem_addr_q <= RESET_PC;
      instr_q    <= NOP_WORD;
      if_pc_q    <= RESET_PC;
      if_valid_q <= 1'b0;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      count_q    <= '0;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      pend_pc_q  <= pend_pc_d;
      mem_req_q  <= mem_req_d;
      mem_addr_q <= mem_addr_d;
      instr_q    <= instr_d;
      if_pc_q    <= if_pc_d;
      if_valid_q <= if_valid_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      count_q    <= count_d;
    end
  end

  // FIFO storage; contents are only meaningful under count_q
  always_ff @(posedge clk_i) begin
    if (push) begin
      fifo_pc_q[wr_ptr_q]   <= mem_addr_q;
      fifo_word_q[wr_ptr_q] <= bus.mem_rdata;
    end
  end
endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Bench for instruction_fetch_unit: constant vector table, hand-written
// corner sequences, then random traffic against a queue-based model.
module tb_instruction_fetch_unit;
  localparam logic [15:0] NOP   = 16'h0800;
  localparam int          DEPTH = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  instruction_fetch_unit_if bus();

  instruction_fetch_unit #(
    .RESET_PC  (16'h0000),
    .NOP_WORD  (NOP),
    .FIFO_DEPTH(DEPTH)
  ) dut (
    .clk_i(clk),
    .rst_i(rst),
    .bus  (bus)
  );

  int total = 0;
  int bad   = 0;

  // ---------------- reference model ----------------
  typedef struct packed {
    logic [15:0] pc;
    logic [15:0] w;
  } ent_t;

  ent_t        q[$];
  logic        m_req, m_valid, m_discard;
  logic [15:0] m_addr, m_fpc, m_pend, m_pc, m_instr;

  task automatic model_reset();
    q.delete();
    m_req = 1'b0; m_valid = 1'b0; m_discard = 1'b0;
    m_addr = 16'h0; m_fpc = 16'h0; m_pend = 16'h0; m_pc = 16'h0; m_instr = NOP;
  endtask

  task automatic model_step(input logic s, input logic rv, input logic [15:0] rp,
                            input logic ak, input logic [15:0] rd);
    bit   popit;
    int   after;
    ent_t e;
    popit = !rv && !s && (q.size() > 0);
    after = q.size() - (popit ? 1 : 0);
    if (rv) begin
      m_instr = NOP; m_valid = 1'b0; q.delete();
    end else if (!s) begin
      if (popit) begin
        e = q.pop_front(); m_pc = e.pc; m_instr = e.w; m_valid = 1'b1;
      end else begin
        m_instr = NOP; m_valid = 1'b0;
      end
    end
    if (!m_req) begin
      if (rv) m_fpc = rp;
      else if (after < DEPTH) begin m_req = 1'b1; m_addr = m_fpc; end
    end else if (ak) begin
      if (m_discard || rv) begin
        m_fpc = rv ? rp : m_pend; m_req = 1'b0; m_discard = 1'b0;
      end else begin
        q.push_back('{pc: m_addr, w: rd});
        m_fpc = m_addr + 16'd1;
        if (after + 1 < DEPTH) m_addr = m_addr + 16'd1;
        else m_req = 1'b0;
      end
    end else if (rv) begin
      m_discard = 1'b1; m_pend = rp;
    end
  endtask

  // ---------------- checking helpers ----------------
  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk_model(input string tag);
    chk({tag, ".mem_req"},     {15'd0, bus.mem_req},  {15'd0, m_req});
    chk({tag, ".mem_addr"},    bus.mem_addr,          m_addr);
    chk({tag, ".instruction"}, bus.instruction,       m_instr);
    chk({tag, ".if_pc"},       bus.if_pc,             m_pc);
    chk({tag, ".if_valid"},    {15'd0, bus.if_valid}, {15'd0, m_valid});
  endtask

  // Called at a negedge: drive inputs, advance model, move to the next negedge.
  // Memory returns addr^A5A5; ack is only offered while a request is up.
  task automatic tick(input logic s, input logic rv, input logic [15:0] rp, input logic ak);
    logic a;
    logic [15:0] rd;
    a  = ak && m_req;
    rd = m_addr ^ 16'hA5A5;
    bus.stall = s; bus.redirect_valid = rv; bus.redirect_pc = rp;
    bus.mem_ack = a; bus.mem_rdata = rd;
    model_step(s, rv, rp, a, rd);
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    bus.stall = 1'b0; bus.redirect_valid = 1'b0; bus.redirect_pc = 16'h0;
    bus.mem_ack = 1'b0; bus.mem_rdata = 16'h0;
    model_reset();
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic        s, rv;
    logic [15:0] rp;
    logic        ak;
    logic        e_req;
    logic [15:0] e_addr;
    logic        e_valid;
    logic [15:0] e_pc, e_instr;
  } vec_t;

  vec_t tbl[10];

  initial begin
    // zero-wait stream from reset, then a 3-cycle ack delay
    tbl[0] = '{1'b0, 1'b0, 16'h0, 1'b0, 1'b1, 16'h0000, 1'b0, 16'h0000, NOP};
    tbl[1] = '{1'b0, 1'b0, 16'h0, 1'b1, 1'b1, 16'h0001, 1'b0, 16'h0000, NOP};
    tbl[2] = '{1'b0, 1'b0, 16'h0, 1'b1, 1'b1, 16'h0002, 1'b1, 16'h0000, 16'hA5A5};
    tbl[3] = '{1'b0, 1'b0, 16'h0, 1'b1, 1'b1, 16'h0003, 1'b1, 16'h0001, 16'hA5A4};
    tbl[4] = '{1'b0, 1'b0, 16'h0, 1'b1, 1'b1, 16'h0004, 1'b1, 16'h0002, 16'hA5A7};
    tbl[5] = '{1'b0, 1'b0, 16'h0, 1'b0, 1'b1, 16'h0004, 1'b1, 16'h0003, 16'hA5A6};
    tbl[6] = '{1'b0, 1'b0, 16'h0, 1'b0, 1'b1, 16'h0004, 1'b0, 16'h0003, NOP};
    tbl[7] = '{1'b0, 1'b0, 16'h0, 1'b0, 1'b1, 16'h0004, 1'b0, 16'h0003, NOP};
    tbl[8] = '{1'b0, 1'b0, 16'h0, 1'b1, 1'b1, 16'h0005, 1'b0, 16'h0003, NOP};
    tbl[9] = '{1'b0, 1'b0, 16'h0, 1'b0, 1'b1, 16'h0005, 1'b1, 16'h0004, 16'hA5A1};

    // ---- reset state ----
    do_reset();
    chk("rst.mem_req",     {15'd0, bus.mem_req},  16'h0);
    chk("rst.mem_addr",    bus.mem_addr,          16'h0);
    chk("rst.instruction", bus.instruction,       NOP);
    chk("rst.if_pc",       bus.if_pc,             16'h0);
    chk("rst.if_valid",    {15'd0, bus.if_valid}, 16'h0);

    // ---- table ----
    for (int i = 0; i < 10; i++) begin
      tick(tbl[i].s, tbl[i].rv, tbl[i].rp, tbl[i].ak);
      chk($sformatf("vec%0d.mem_req", i),     {15'd0, bus.mem_req},  {15'd0, tbl[i].e_req});
      chk($sformatf("vec%0d.mem_addr", i),    bus.mem_addr,          tbl[i].e_addr);
      chk($sformatf("vec%0d.if_valid", i),    {15'd0, bus.if_valid}, {15'd0, tbl[i].e_valid});
      chk($sformatf("vec%0d.if_pc", i),       bus.if_pc,             tbl[i].e_pc);
      chk($sformatf("vec%0d.instruction", i), bus.instruction,       tbl[i].e_instr);
    end

    // ---- stall 5 cycles with FIFO filling ----
    for (int i = 0; i < 5; i++) begin
      tick(1'b1, 1'b0, 16'h0, 1'b1);
      chk_model("stall");
      chk("stall.held_pc", bus.if_pc, 16'h0004);
    end
    chk("stall.req_dropped", {15'd0, bus.mem_req}, 16'h0);
    for (int i = 0; i < 6; i++) begin
      tick(1'b0, 1'b0, 16'h0, 1'b1);
      chk_model("unstall");
    end

    // ---- redirect while request pending without ack ----
    do_reset();
    tick(1'b0, 1'b0, 16'h0, 1'b0);     chk_model("rdp.issue");
    tick(1'b0, 1'b1, 16'h0040, 1'b0);  chk_model("rdp.redir");
    chk("rdp.req_held", {15'd0, bus.mem_req}, 16'h1);
    tick(1'b0, 1'b0, 16'h0, 1'b1);     chk_model("rdp.drain");
    tick(1'b0, 1'b0, 16'h0, 1'b0);     chk_model("rdp.reissue");
    chk("rdp.new_addr", bus.mem_addr, 16'h0040);
    tick(1'b0, 1'b0, 16'h0, 1'b1);     chk_model("rdp.push");
    tick(1'b0, 1'b0, 16'h0, 1'b1);     chk_model("rdp.pop");
    chk("rdp.if_pc", bus.if_pc, 16'h0040);
    chk("rdp.if_valid", {15'd0, bus.if_valid}, 16'h1);

    // ---- redirect with stall and same-edge ack ----
    do_reset();
    tick(1'b0, 1'b0, 16'h0, 1'b0);     chk_model("rsa.issue");
    tick(1'b1, 1'b0, 16'h0, 1'b1);     chk_model("rsa.push");
    tick(1'b1, 1'b1, 16'h1234, 1'b1);  chk_model("rsa.redir");
    chk("rsa.if_valid", {15'd0, bus.if_valid}, 16'h0);
    chk("rsa.instruction", bus.instruction, NOP);
    chk("rsa.mem_req", {15'd0, bus.mem_req}, 16'h0);
    tick(1'b1, 1'b0, 16'h0, 1'b0);     chk_model("rsa.reissue");
    chk("rsa.new_addr", bus.mem_addr, 16'h1234);
    tick(1'b0, 1'b0, 16'h0, 1'b1);     chk_model("rsa.push2");
    chk("rsa.flushed", {15'd0, bus.if_valid}, 16'h0);
    tick(1'b0, 1'b0, 16'h0, 1'b1);     chk_model("rsa.pop");
    chk("rsa.if_pc", bus.if_pc, 16'h1234);

    // ---- wrap FFFF -> 0000, then reset mid-request ----
    do_reset();
    tick(1'b0, 1'b1, 16'hFFFF, 1'b0);  chk_model("wrap.redir");
    tick(1'b0, 1'b0, 16'h0, 1'b0);     chk_model("wrap.issue");
    chk("wrap.addr", bus.mem_addr, 16'hFFFF);
    tick(1'b0, 1'b0, 16'h0, 1'b1);     chk_model("wrap.push");
    tick(1'b0, 1'b0, 16'h0, 1'b1);     chk_model("wrap.popF");
    chk("wrap.pcF", bus.if_pc, 16'hFFFF);
    chk("wrap.instrF", bus.instruction, 16'h5A5A);
    tick(1'b0, 1'b0, 16'h0, 1'b1);     chk_model("wrap.pop0");
    chk("wrap.pc0", bus.if_pc, 16'h0000);
    chk("wrap.instr0", bus.instruction, 16'hA5A5);
    chk("wrap.in_req", {15'd0, bus.mem_req}, 16'h1);
    #2 rst = 1'b1;
    #1;
    chk("arst.mem_req",     {15'd0, bus.mem_req},  16'h0);
    chk("arst.mem_addr",    bus.mem_addr,          16'h0);
    chk("arst.instruction", bus.instruction,       NOP);
    chk("arst.if_pc",       bus.if_pc,             16'h0);
    chk("arst.if_valid",    {15'd0, bus.if_valid}, 16'h0);
    @(negedge clk);

    // ---- random traffic against the model ----
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      logic        s, rv, ak;
      logic [15:0] rp;
      s  = ($urandom_range(0, 3) == 0);
      rv = ($urandom_range(0, 15) == 0);
      ak = ($urandom_range(0, 1) == 1);
      rp = ($urandom_range(0, 3) == 0) ? 16'hFFFE : 16'($urandom);
      tick(s, rv, rp, ak);
      chk_model("rand");
      if (q.size() > DEPTH) begin
        total++; bad++;
        $display("FAIL rand.model_depth: got %0d expected <= %0d", q.size(), DEPTH);
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
